// File: rtl/gb_camera_pkg.sv
// Shared types and constants for the Game Boy Camera capture block.
//   cam_state_e : capture sequencer states
//   register map offsets, image geometry, RAM base of the tile image
//   tile_addr() : 2bpp tile byte address of pixel row (x,y), low plane
package gb_camera_pkg;

  typedef enum logic [2:0] {IDLE, EXPOSE, FETCH, WR_LO, WR_HI} cam_state_e;

  localparam int NUM_REGS     = 54;
  localparam int REG_CTRL     = 0;
  localparam int REG_EXP_HI   = 2;
  localparam int REG_EXP_LO   = 3;
  localparam int REG_DITHER   = 6;
  localparam int DITHER_BYTES = 48;

  localparam int          IMG_W    = 128;
  localparam int          IMG_H    = 112;
  localparam logic [11:0] IMG_BASE = 12'h100;

  // Tiles are 16 bytes, 16 tiles per tile row, two bytes per pixel row:
  // the bitfield {tile_y, tile_x, row, plane} is exactly that layout.
  function automatic logic [11:0] tile_addr(logic [6:0] x, logic [6:0] y);
    return IMG_BASE + {y[6:3], x[6:3], y[2:0], 1'b0};
  endfunction

endpackage

// File: rtl/gb_camera_dither.sv
// Combinational 2-bit quantiser using the 4x4 threshold matrix.
//   pix    : 8-bit luminance, 0 = dark
//   x, y   : low two bits of the pixel position (matrix cell select)
//   matrix : 48 threshold bytes, 3 per cell, cell i = y*4 + x
//   color  : 3 = darkest .. 0 = lightest
module gb_camera_dither
  import gb_camera_pkg::*;
(
  input  logic [7:0]                   pix,
  input  logic [1:0]                   x,
  input  logic [1:0]                   y,
  input  logic [DITHER_BYTES-1:0][7:0] matrix,
  output logic [1:0]                   color
);

  logic [5:0] base;
  logic [7:0] t0, t1, t2;

  always_comb begin
    base = {2'b00, y, x} * 6'd3;
    t0   = matrix[base];
    t1   = matrix[base + 6'd1];
    t2   = matrix[base + 6'd2];
    if (pix < t0)      color = 2'd3;
    else if (pix < t1) color = 2'd2;
    else if (pix < t2) color = 2'd1;
    else               color = 2'd0;
  end

endmodule

// File: rtl/gb_camera_capture.sv
// Game Boy Camera sensor-side capture engine.
//   CPU side : cam_sel/cpu_addr/cpu_wr/cpu_di/cpu_do, 54-byte register file,
//              writes and exposure timing qualified by ce_cpu
//   Sensor   : pix_req/pix_x/pix_y out, pix_valid/pix_data back
//   Cart RAM : ram_we/ram_addr/ram_data, held while ram_wait
//   busy     : capture in progress (also read back as reg0 bit0)
module gb_camera_capture
  import gb_camera_pkg::*;
#(
  parameter int EXP_SCALE  = 16,
  parameter int BASE_DELAY = 32768
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce_cpu,
  input  logic        cam_sel,
  input  logic [6:0]  cpu_addr,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_di,
  output logic [7:0]  cpu_do,
  output logic        busy,
  output logic        pix_req,
  output logic [6:0]  pix_x,
  output logic [6:0]  pix_y,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [7:0]  ram_data,
  input  logic        ram_wait
);

  logic [7:0]                   regs [NUM_REGS];
  logic [DITHER_BYTES-1:0][7:0] matrix;
  cam_state_e                   state;
  logic [23:0]                  exp_cnt, exp_load;
  logic [6:0]                   x, y;
  logic [7:0]                   lo, hi;
  logic [1:0]                   color;
  logic                         reg_wr, ctrl_wr, trig, abort, last_px, done;

  always_comb begin
    reg_wr   = ce_cpu & cam_sel & cpu_wr & (cpu_addr < 7'(NUM_REGS));
    ctrl_wr  = reg_wr & (cpu_addr == 7'(REG_CTRL));
    trig     = ctrl_wr & cpu_di[0] & (state == IDLE);
    abort    = ctrl_wr & ~cpu_di[0] & (state != IDLE);
    last_px  = (x == 7'(IMG_W - 1)) && (y == 7'(IMG_H - 1));
    done     = (state == WR_HI) && !ram_wait && last_px;
    exp_load = 24'(BASE_DELAY)
             + 24'({regs[REG_EXP_HI], regs[REG_EXP_LO]}) * 24'(EXP_SCALE);
  end

  assign cpu_do = (cpu_addr == 7'(REG_CTRL)) ? {regs[REG_CTRL][7:1], busy} : 8'h00;
  assign pix_x  = x;
  assign pix_y  = y;

  // Register file; the sequencer drops the trigger bit when the image is done.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (reg_wr) regs[cpu_addr[5:0]] <= cpu_di;
      if (done)   regs[REG_CTRL][0]   <= 1'b0;
    end
  end

  for (genvar k = 0; k < DITHER_BYTES; k++) begin : g_mat
    assign matrix[k] = regs[REG_DITHER + k];
  end

  // Thresholds are read live, so a mid-capture write hits the next pixel.
  gb_camera_dither u_dither (
    .pix    (pix_data),
    .x      (x[1:0]),
    .y      (y[1:0]),
    .matrix (matrix),
    .color  (color)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      pix_req  <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      exp_cnt  <= '0;
      x        <= '0;
      y        <= '0;
      lo       <= '0;
      hi       <= '0;
    end else if (abort) begin
      // Whatever write is on the bus this cycle is the last one.
      state   <= IDLE;
      busy    <= 1'b0;
      pix_req <= 1'b0;
      ram_we  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (trig) begin
          exp_cnt <= exp_load;
          busy    <= 1'b1;
          state   <= EXPOSE;
        end
        EXPOSE: if (ce_cpu) begin
          // <=1 also covers a zero load (BASE_DELAY=0, exposure=0).
          if (exp_cnt <= 24'd1) begin
            exp_cnt <= '0;
            x       <= '0;
            y       <= '0;
            pix_req <= 1'b1;
            state   <= FETCH;
          end else begin
            exp_cnt <= exp_cnt - 24'd1;
          end
        end
        FETCH: if (pix_req && pix_valid) begin
          lo <= {lo[6:0], color[0]};
          hi <= {hi[6:0], color[1]};
          if (x[2:0] == 3'd7) begin
            // x stays on the group's last column until the hi byte is out.
            pix_req  <= 1'b0;
            ram_we   <= 1'b1;
            ram_addr <= tile_addr(x, y);
            ram_data <= {lo[6:0], color[0]};
            state    <= WR_LO;
          end else begin
            x <= x + 7'd1;
          end
        end
        WR_LO: if (!ram_wait) begin
          ram_addr <= ram_addr | 12'h001;
          ram_data <= hi;
          state    <= WR_HI;
        end
        WR_HI: if (!ram_wait) begin
          ram_we <= 1'b0;
          if (last_px) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            x       <= x + 7'd1;
            if (x == 7'(IMG_W - 1)) y <= y + 7'd1;
            pix_req <= 1'b1;
            state   <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gb_camera_capture.sv
module tb_gb_camera_capture;

  localparam int BASE  = 4;
  localparam int SCALE = 16;

  logic        clk_sys = 1'b0, reset_n = 1'b0, ce_cpu = 1'b0;
  logic        cam_sel = 1'b0, cpu_wr = 1'b0, pix_valid = 1'b0, ram_wait = 1'b0;
  logic [6:0]  cpu_addr = '0;
  logic [7:0]  cpu_di = '0, pix_data = '0;
  logic [7:0]  cpu_do, ram_data;
  logic        busy, pix_req, ram_we;
  logic [6:0]  pix_x, pix_y;
  logic [11:0] ram_addr;

  gb_camera_capture #(.EXP_SCALE(SCALE), .BASE_DELAY(BASE)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_cpu(ce_cpu), .cam_sel(cam_sel),
    .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_di(cpu_di), .cpu_do(cpu_do),
    .busy(busy), .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid), .pix_data(pix_data), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wait(ram_wait)
  );

  always #5 clk_sys = ~clk_sys;

  // ---------------- reference state ----------------
  logic [7:0] pix_mem [0:111][0:127];
  logic [7:0] thr_mem [0:47];
  logic [7:0] ram_img [0:4095];

  int  n_vec = 0, n_err = 0;
  int  wr_idx = 0, late_cnt = 0, first_addr = -1, last_addr = -1, exp_ticks = 0;
  bit  aborted = 0, seen_req = 0, stall = 0, acc_pending = 0, ce_ph = 0;
  bit  hold_prev = 0;
  logic [11:0] hold_addr;
  logic [7:0]  hold_data;
  int  wait_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_color(int x, int y);
    int i = (y % 4) * 4 + (x % 4);
    logic [7:0] p = pix_mem[y][x];
    if (p < thr_mem[3*i])   return 2'd3;
    if (p < thr_mem[3*i+1]) return 2'd2;
    if (p < thr_mem[3*i+2]) return 2'd1;
    return 2'd0;
  endfunction

  // n-th write of a capture: rows top to bottom, 8-pixel groups left to right, lo then hi.
  function automatic int model_addr(int n);
    int p = n / 2;
    int row = p / 16;
    int grp = p % 16;
    return 'h100 + ((row / 8) * 16 + grp) * 16 + (row % 8) * 2 + n % 2;
  endfunction

  // Byte content from 2bpp tile layout: 16 B/tile, 16 tiles/row, leftmost pixel = bit 7.
  function automatic logic [7:0] model_byte(int a);
    int off, tile, r, h, y, tx;
    logic [7:0] b = 8'h00;
    logic [1:0] c;
    if (a < 'h100 || a > 'hEFF) return 8'h00;
    off = a - 'h100; tile = off / 16; r = (off % 16) / 2; h = off % 2;
    y = (tile / 16) * 8 + r; tx = tile % 16;
    for (int k = 0; k < 8; k++) begin
      c = model_color(tx * 8 + k, y);
      b[7-k] = h ? c[1] : c[0];
    end
    return b;
  endfunction

  // ---------------- input drivers (just after the active edge) ----------------
  always @(posedge clk_sys) begin
    #1;
    ce_ph  = !ce_ph;
    ce_cpu = ce_ph;
    if (acc_pending) wait_cnt = stall ? int'($urandom_range(0, 6)) : 0;
    if (pix_req) begin
      if (wait_cnt == 0) begin
        pix_valid = 1'b1;
        pix_data  = pix_mem[pix_y][pix_x];
      end else begin
        pix_valid = 1'b0;
        pix_data  = 8'($urandom);
        wait_cnt--;
      end
    end else begin
      // Stray strobes with no request outstanding must be ignored.
      pix_valid = stall ? 1'($urandom_range(0, 1)) : 1'b0;
      pix_data  = 8'($urandom);
    end
    ram_wait = stall && ($urandom_range(0, 3) == 0);
  end

  // ---------------- monitor (opposite edge) ----------------
  always @(negedge clk_sys) begin
    acc_pending = pix_req && pix_valid;
    if (!reset_n) begin
      hold_prev = 0;
    end else begin
      if (busy && !seen_req && !pix_req && ce_cpu) exp_ticks++;
      if (pix_req) seen_req = 1;
      if (hold_prev && busy) begin
        check("hold_we",   int'(ram_we),   1);
        check("hold_addr", int'(ram_addr), int'(hold_addr));
        check("hold_data", int'(ram_data), int'(hold_data));
      end
      if (ram_we && !ram_wait) begin
        if (aborted) late_cnt++;
        else begin
          check("wr_range", int'(ram_addr >= 12'h100 && ram_addr <= 12'hEFF), 1);
          check("wr_addr", int'(ram_addr), model_addr(wr_idx));
          check("wr_data", int'(ram_data), int'(model_byte(int'(ram_addr))));
          ram_img[ram_addr] = ram_data;
          if (wr_idx == 0) first_addr = int'(ram_addr);
          last_addr = int'(ram_addr);
          wr_idx++;
        end
      end
      hold_prev = ram_we && ram_wait;
      hold_addr = ram_addr;
      hold_data = ram_data;
    end
  end

  // ---------------- CPU tasks ----------------
  task automatic cpu_write(input logic [6:0] a, input logic [7:0] d, input logic sel);
    @(negedge clk_sys);
    cam_sel = sel; cpu_wr = 1'b1; cpu_addr = a; cpu_di = d;
    while (!ce_cpu) @(negedge clk_sys);
    @(negedge clk_sys);
    cpu_wr = 1'b0; cam_sel = 1'b0;
  endtask

  task automatic cpu_read_chk(input string name, input logic [6:0] a, input logic [7:0] exp);
    @(negedge clk_sys);
    cpu_addr = a;
    #1;
    check(name, int'(cpu_do), int'(exp));
  endtask

  task automatic write_thr();
    for (int k = 0; k < 48; k++) cpu_write(7'(6 + k), thr_mem[k], 1'b1);
  endtask

  task automatic fill_pix(input int mode, input logic [7:0] v);
    for (int yy = 0; yy < 112; yy++)
      for (int xx = 0; xx < 128; xx++)
        pix_mem[yy][xx] = (mode == 0) ? v : 8'($urandom);
  endtask

  // stop_y < 0: run to completion; otherwise abort once row stop_y is being fetched.
  task automatic run_capture(input logic [15:0] expv, input int stop_y);
    int c;
    wr_idx = 0; aborted = 0; late_cnt = 0; first_addr = -1; last_addr = -1;
    for (int i = 0; i < 4096; i++) ram_img[i] = 8'h00;
    cpu_write(7'd2, expv[15:8], 1'b1);
    cpu_write(7'd3, expv[7:0], 1'b1);
    exp_ticks = 0; seen_req = 0;
    cpu_write(7'd0, 8'h01, 1'b1);
    check("trigger_busy", int'(busy), 1);
    check("trigger_read", int'(cpu_do), 'h01);
    if (stop_y < 0) begin
      for (c = 0; c < 30000 && busy; c++) @(negedge clk_sys);
      check("capture_done", int'(busy), 0);
    end else begin
      for (c = 0; c < 40000 && !(busy && pix_y == 7'(stop_y)); c++) @(negedge clk_sys);
      check("reach_row", int'(pix_y), stop_y);
      cpu_write(7'd0, 8'h00, 1'b1);
      check("abort_busy", int'(busy), 0);
      check("abort_req", int'(pix_req), 0);
      aborted = 1;
      repeat (30) @(negedge clk_sys);
      check("no_late_writes", late_cnt, 0);
    end
  endtask

  typedef struct {
    logic       wr;
    logic       sel;
    logic [6:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } reg_vec_t;

  reg_vec_t vecs [9];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 7'h10, 8'h55, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 7'h40, 8'hAA, 8'h00};
    vecs[2] = '{1'b0, 1'b1, 7'h00, 8'h00, 8'h00};
    vecs[3] = '{1'b1, 1'b1, 7'h00, 8'hA4, 8'hA4};
    vecs[4] = '{1'b1, 1'b0, 7'h00, 8'hFE, 8'hA4};
    vecs[5] = '{1'b1, 1'b1, 7'h00, 8'h00, 8'h00};
    vecs[6] = '{1'b1, 1'b1, 7'h35, 8'h12, 8'h00};
    vecs[7] = '{1'b0, 1'b1, 7'h7F, 8'h00, 8'h00};
    vecs[8] = '{1'b1, 1'b1, 7'h01, 8'hFF, 8'h00};

    // reset state
    repeat (3) @(negedge clk_sys);
    check("rst_busy", int'(busy), 0);
    check("rst_req", int'(pix_req), 0);
    check("rst_we", int'(ram_we), 0);
    check("rst_addr", int'(ram_addr), 0);
    check("rst_data", int'(ram_data), 0);
    check("rst_cpu_do", int'(cpu_do), 0);
    reset_n = 1'b1;

    // register file / read-back table
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wr) cpu_write(vecs[i].addr, vecs[i].data, vecs[i].sel);
      cpu_read_chk($sformatf("regvec%0d", i), vecs[i].addr, vecs[i].exp);
    end
    check("idle_busy", int'(busy), 0);

    // minimal capture: dark pixels, thresholds 0x80 -> all bytes 0xFF
    fill_pix(0, 8'h00);
    for (int k = 0; k < 48; k++) thr_mem[k] = 8'h80;
    write_thr();
    run_capture(16'h0000, -1);
    check("min_expose", exp_ticks, BASE);
    check("min_count", wr_idx, 3584);
    check("min_first", first_addr, 'h100);
    check("min_last", last_addr, 'hEFF);
    begin
      int nff = 0;
      for (int a = 'h100; a <= 'hEFF; a++) if (ram_img[a] == 8'hFF) nff++;
      check("min_all_ff", nff, 3584);
    end
    cpu_read_chk("min_reg0_clear", 7'h00, 8'h00);

    // tile addressing: one bright pixel at (8,9) -> tile (1,1) row 1
    pix_mem[9][8] = 8'hFF;
    run_capture(16'h0000, 16);
    check("tile_lo", int'(ram_img[12'h212]), 'h7F);
    check("tile_hi", int'(ram_img[12'h213]), 'h7F);
    check("tile_other", int'(ram_img[12'h210]), 'hFF);

    // dither: cell 5 = 40/80/C0, rest FF; pixels 0x90
    fill_pix(0, 8'h90);
    for (int k = 0; k < 48; k++) thr_mem[k] = 8'hFF;
    thr_mem[15] = 8'h40; thr_mem[16] = 8'h80; thr_mem[17] = 8'hC0;
    write_thr();
    run_capture(16'h0000, 4);
    check("dith_row0_lo", int'(ram_img[12'h100]), 'hFF);
    check("dith_row0_hi", int'(ram_img[12'h101]), 'hFF);
    check("dith_row1_lo", int'(ram_img[12'h102]), 'hFF);
    check("dith_row1_hi", int'(ram_img[12'h103]), 'hBB);

    // random thresholds and pixels, full image, nonzero exposure
    fill_pix(1, 8'h00);
    for (int k = 0; k < 48; k++) thr_mem[k] = 8'($urandom);
    write_thr();
    run_capture(16'h0003, -1);
    check("rnd_expose", exp_ticks, BASE + 3 * SCALE);
    check("rnd_count", wr_idx, 3584);
    check("rnd_last", last_addr, 'hEFF);

    // same image under sensor/RAM backpressure, aborted at row 20
    stall = 1;
    run_capture(16'h0000, 20);
    check("stall_progress", int'(wr_idx >= 640), 1);
    stall = 0;

    // restart after abort begins again at the image base; then async reset mid-capture
    wr_idx = 0; aborted = 0; late_cnt = 0; first_addr = -1;
    cpu_write(7'd0, 8'h01, 1'b1);
    for (int c = 0; c < 5000 && wr_idx < 4; c++) @(negedge clk_sys);
    check("restart_writes", int'(wr_idx >= 4), 1);
    check("restart_first", first_addr, 'h100);
    @(negedge clk_sys);
    reset_n = 1'b0;
    aborted = 1;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_we", int'(ram_we), 0);
    check("arst_req", int'(pix_req), 0);
    check("arst_addr", int'(ram_addr), 0);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (20) @(negedge clk_sys);
    check("arst_no_writes", late_cnt, 0);
    cpu_read_chk("arst_reg0", 7'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
